// File: rtl/bram_multibank_ring_if.sv
// Fill/consume bus of the multi-bank ring buffer. The master drives the fill
// and consume requests; the slave is the ring itself.
interface bram_multibank_ring_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned BANK_W = 2
);
   logic              flush;
   logic [31:0]       seg_words;
   logic              fill_req;
   logic              fill_ready;
   logic              fill_busy;
   logic              fill_we;
   logic [ADDR_W-1:0] fill_addr;
   logic [DATA_W-1:0] fill_wdata;
   logic              fill_done;
   logic              cons_mode;
   logic              consume_req;
   logic              consume_ready;
   logic              consume_busy;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_rdata;
   logic              rd_valid;
   logic              cons_commit;
   logic              consume_done;
   logic [BANK_W-1:0] fill_bank;
   logic [BANK_W-1:0] active_bank;
   logic [BANK_W:0]   full_count;
   logic [1:0]        err;

   modport master (
      output flush, seg_words, fill_req, fill_we, fill_addr, fill_wdata, cons_mode, consume_req,
             rd_en, rd_addr, cons_commit,
      input  fill_ready, fill_busy, fill_done, consume_ready, consume_busy, rd_rdata, rd_valid,
             consume_done, fill_bank, active_bank, full_count, err
   );

   modport slave (
      input  flush, seg_words, fill_req, fill_we, fill_addr, fill_wdata, cons_mode, consume_req,
             rd_en, rd_addr, cons_commit,
      output fill_ready, fill_busy, fill_done, consume_ready, consume_busy, rd_rdata, rd_valid,
             consume_done, fill_bank, active_bank, full_count, err
   );
endinterface

// File: rtl/bram_multibank_ring.sv
// N-bank round-robin ring buffer on inferred simple-dual-port RAM.
// Define BRAM_RING_OUT_REG_EN for a 2-cycle registered read with consume_done aligned to last beat.
module bram_multibank_ring #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned ADDR_W    = $clog2(DEPTH),
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned BANK_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
   input logic                  clk,
   input logic                  rstn,
   bram_multibank_ring_if.slave bus
);
   localparam int unsigned LenW = ADDR_W + 1;
   localparam logic [BANK_W-1:0] LastBank = BANK_W'(NUM_BANKS - 1);

   typedef enum logic [1:0] {StEmpty, StFill, StFull, StActive} bank_state_e;

   bank_state_e       bank_q [NUM_BANKS];
   logic [LenW-1:0]   seg_len_q [NUM_BANKS];
   logic [DATA_W-1:0] mem [NUM_BANKS*DEPTH];

   logic              filling_q, consuming_q, mode_q, fill_done_q, consume_done_q;
   logic [BANK_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LenW-1:0]   fill_count_q, cons_count_q;
   logic [BANK_W:0]   full_count_q;
   logic [1:0]        err_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;

   logic            fill_ready, consume_ready, fill_acc, cons_acc, fill_wr, fill_last;
   logic            rd_ok, mode0_last, cons_evt, cons_fin;
   logic [LenW-1:0] seg_len_new;

   function automatic logic [BANK_W-1:0] bump(input logic [BANK_W-1:0] p);
      return (p == LastBank) ? '0 : p + 1'b1;
   endfunction

   assign fill_ready    = !filling_q && (bank_q[wr_ptr_q] == StEmpty);
   assign consume_ready = !consuming_q && (bank_q[rd_ptr_q] == StFull);
   assign fill_acc      = bus.fill_req && fill_ready;
   assign cons_acc      = bus.consume_req && consume_ready;
   assign fill_wr       = bus.fill_we && filling_q;
   assign fill_last     = fill_wr && ((fill_count_q + LenW'(1)) == seg_len_q[wr_ptr_q]);
   assign mode0_last    = rd_ok && ((cons_count_q + LenW'(1)) == seg_len_q[rd_ptr_q]);
   // Zero or oversize lengths mean a whole bank.
   assign seg_len_new   = (bus.seg_words == 32'd0 || bus.seg_words > DEPTH) ?
                          LenW'(DEPTH) : LenW'(bus.seg_words);

`ifdef BRAM_RING_OUT_REG_EN
   logic              pend_q, rd_valid2_q;
   logic [DATA_W-1:0] rd_data2_q;

   // Completion waits one cycle so consume_done lines up with the last output beat.
   assign rd_ok    = bus.rd_en && consuming_q && !pend_q;
   assign cons_evt = consuming_q && !pend_q && (mode_q ? bus.cons_commit : mode0_last);
   assign cons_fin = pend_q;

   always_ff @(posedge clk) begin
      if (!rstn || bus.flush) begin
         pend_q      <= 1'b0;
         rd_valid2_q <= 1'b0;
         rd_data2_q  <= '0;
      end else begin
         pend_q      <= cons_evt;
         rd_valid2_q <= rd_valid_q;
         if (rd_valid_q) rd_data2_q <= rd_data_q;
      end
   end

   assign bus.rd_valid = rd_valid2_q;
   assign bus.rd_rdata = rd_data2_q;
`else
   assign rd_ok    = bus.rd_en && consuming_q;
   assign cons_evt = consuming_q && (mode_q ? bus.cons_commit : mode0_last);
   assign cons_fin = cons_evt;

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_rdata = rd_data_q;
`endif

   // RAM contents survive reset and flush.
   always_ff @(posedge clk) begin
      if (fill_wr) mem[{wr_ptr_q, bus.fill_addr}] <= bus.fill_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rstn || bus.flush) begin
         for (int i = 0; i < int'(NUM_BANKS); i++) begin
            bank_q[i]    <= StEmpty;
            seg_len_q[i] <= '0;
         end
         filling_q      <= 1'b0;
         consuming_q    <= 1'b0;
         mode_q         <= 1'b0;
         fill_done_q    <= 1'b0;
         consume_done_q <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fill_count_q   <= '0;
         cons_count_q   <= '0;
         full_count_q   <= '0;
         err_q          <= '0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= '0;
      end else begin
         fill_done_q    <= fill_last;
         consume_done_q <= cons_fin;
         rd_valid_q     <= rd_ok;
         err_q          <= err_q | {bus.rd_en && !consuming_q, bus.fill_we && !filling_q};

         if (fill_acc) begin
            bank_q[wr_ptr_q]    <= StFill;
            seg_len_q[wr_ptr_q] <= seg_len_new;
            fill_count_q        <= '0;
            filling_q           <= 1'b1;
         end
         if (fill_wr) fill_count_q <= fill_count_q + LenW'(1);
         if (fill_last) begin
            bank_q[wr_ptr_q] <= StFull;
            filling_q        <= 1'b0;
            wr_ptr_q         <= bump(wr_ptr_q);
         end

         if (cons_acc) begin
            bank_q[rd_ptr_q] <= StActive;
            mode_q           <= bus.cons_mode;
            cons_count_q     <= '0;
            consuming_q      <= 1'b1;
         end
         if (rd_ok) begin
            cons_count_q <= cons_count_q + LenW'(1);
            rd_data_q    <= mem[{rd_ptr_q, bus.rd_addr}];
         end
         if (cons_fin) begin
            bank_q[rd_ptr_q] <= StEmpty;
            consuming_q      <= 1'b0;
            rd_ptr_q         <= bump(rd_ptr_q);
         end

         if (fill_last && !cons_acc)      full_count_q <= full_count_q + 1'b1;
         else if (cons_acc && !fill_last) full_count_q <= full_count_q - 1'b1;
      end
   end

   assign bus.fill_ready    = fill_ready;
   assign bus.consume_ready = consume_ready;
   assign bus.fill_busy     = filling_q;
   assign bus.consume_busy  = consuming_q;
   assign bus.fill_done     = fill_done_q;
   assign bus.consume_done  = consume_done_q;
   assign bus.fill_bank     = wr_ptr_q;
   assign bus.active_bank   = rd_ptr_q;
   assign bus.full_count    = full_count_q;
   assign bus.err           = err_q;
endmodule

// File: tb/tb_bram_multibank_ring.sv
// Directed bench for bram_multibank_ring (default 1-cycle read latency build).
module tb_bram_multibank_ring;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned NB     = 4;
   localparam int unsigned BANK_W = 2;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   bram_multibank_ring_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

   bram_multibank_ring #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_BANKS(NB), .BANK_W(BANK_W)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int r, input int b, input int a);
      return 32'((r << 16) | (b << 8) | a);
   endfunction

   // Fill bank b with n words; optionally race a consume_req against the last write.
   task automatic do_fill(input int b, input int n, input int seg, input int r, input bit race);
      chk("fill_bank", 64'(bus.fill_bank), 64'(b));
      chk("fill_ready", 64'(bus.fill_ready), 64'd1);
      bus.seg_words = 32'(seg);
      bus.fill_req  = 1'b1;
      tick();
      bus.fill_req  = 1'b0;
      bus.seg_words = 32'd5;
      chk("fill_busy_start", 64'(bus.fill_busy), 64'd1);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) begin
            chk("fill_done_early", 64'(bus.fill_done), 64'd0);
            chk("fill_busy_before_last", 64'(bus.fill_busy), 64'd1);
         end
         bus.fill_we     = 1'b1;
         bus.fill_addr   = 6'(i);
         bus.fill_wdata  = pat(r, b, i);
         bus.consume_req = race && (i == n - 1);
         tick();
      end
      bus.fill_we     = 1'b0;
      bus.consume_req = 1'b0;
      chk("fill_done", 64'(bus.fill_done), 64'd1);
      chk("fill_busy_end", 64'(bus.fill_busy), 64'd0);
      if (race) chk("race_consume_rejected", 64'(bus.consume_busy), 64'd0);
      tick();
      chk("fill_done_pulse", 64'(bus.fill_done), 64'd0);
   endtask

   // Consume bank b with n reads at address i % w; mode 1 finishes with a commit.
   task automatic do_consume(input int b, input int n, input int w, input bit mode, input int r);
      logic [31:0] last;
      chk("active_bank", 64'(bus.active_bank), 64'(b));
      chk("consume_ready", 64'(bus.consume_ready), 64'd1);
      bus.cons_mode   = mode;
      bus.consume_req = 1'b1;
      tick();
      bus.consume_req = 1'b0;
      chk("consume_busy_start", 64'(bus.consume_busy), 64'd1);
      last = '0;
      for (int i = 0; i < n; i++) begin
         bus.rd_en       = 1'b1;
         bus.rd_addr     = 6'(i % w);
         bus.cons_commit = !mode && (i == 0);
         tick();
         last = pat(r, b, i % w);
         chk("rd_valid", 64'(bus.rd_valid), 64'd1);
         chk("rd_rdata", 64'(bus.rd_rdata), 64'(last));
         chk("consume_done_beat", 64'(bus.consume_done), 64'(!mode && i == n - 1));
         chk("consume_busy_beat", 64'(bus.consume_busy), 64'(mode || i < n - 1));
      end
      bus.rd_en       = 1'b0;
      bus.cons_commit = 1'b0;
      if (mode) begin
         bus.cons_commit = 1'b1;
         tick();
         bus.cons_commit = 1'b0;
         chk("commit_done", 64'(bus.consume_done), 64'd1);
         chk("commit_busy", 64'(bus.consume_busy), 64'd0);
      end
      tick();
      chk("consume_done_pulse", 64'(bus.consume_done), 64'd0);
      chk("rd_valid_idle", 64'(bus.rd_valid), 64'd0);
      chk("rd_rdata_hold", 64'(bus.rd_rdata), 64'(last));
      chk("active_bank_next", 64'(bus.active_bank), 64'((b + 1) % NB));
   endtask

   initial begin
      rstn            = 1'b0;
      bus.flush       = 1'b0;
      bus.seg_words   = '0;
      bus.fill_req    = 1'b0;
      bus.fill_we     = 1'b0;
      bus.fill_addr   = '0;
      bus.fill_wdata  = '0;
      bus.cons_mode   = 1'b0;
      bus.consume_req = 1'b0;
      bus.rd_en       = 1'b0;
      bus.rd_addr     = '0;
      bus.cons_commit = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      chk("rst_fill_ready", 64'(bus.fill_ready), 64'd1);
      chk("rst_consume_ready", 64'(bus.consume_ready), 64'd0);
      chk("rst_full_count", 64'(bus.full_count), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      chk("rst_banks", 64'({bus.fill_bank, bus.active_bank}), 64'd0);
      chk("rst_flags", 64'({bus.fill_busy, bus.consume_busy, bus.rd_valid, bus.rd_rdata}), 64'd0);

      // Four full-depth banks, then a dropped fifth request.
      for (int b = 0; b < 4; b++) begin
         do_fill(b, 64, 0, 0, 1'b0);
         chk("full_count_inc", 64'(bus.full_count), 64'(b + 1));
      end
      chk("all_full_ready", 64'(bus.fill_ready), 64'd0);
      bus.fill_req = 1'b1;
      tick();
      bus.fill_req = 1'b0;
      chk("fifth_dropped_busy", 64'(bus.fill_busy), 64'd0);
      chk("fifth_dropped_count", 64'(bus.full_count), 64'd4);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush1_full_count", 64'(bus.full_count), 64'd0);

      // Mode 0, ten words; mode 1, twenty reads then commit; clamped 100-word segment.
      do_fill(0, 10, 10, 0, 1'b0);
      do_consume(0, 10, 10, 1'b0, 0);
      do_fill(1, 10, 10, 0, 1'b0);
      do_consume(1, 20, 10, 1'b1, 0);
      do_fill(2, 64, 100, 0, 1'b0);
      do_consume(2, 64, 64, 1'b0, 0);

      // Two full banks plus a half-filled one, then flush.
      do_fill(3, 4, 4, 0, 1'b1);
      do_fill(0, 4, 4, 0, 1'b0);
      bus.seg_words = 32'd8;
      bus.fill_req  = 1'b1;
      tick();
      bus.fill_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.fill_we    = 1'b1;
         bus.fill_addr  = 6'(i);
         bus.fill_wdata = pat(0, 1, i);
         tick();
      end
      bus.fill_we = 1'b0;
      chk("pre_flush_full_count", 64'(bus.full_count), 64'd2);
      chk("pre_flush_busy", 64'(bus.fill_busy), 64'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_full_count", 64'(bus.full_count), 64'd0);
      chk("flush_ptrs", 64'({bus.fill_bank, bus.active_bank}), 64'd0);
      chk("flush_busy", 64'({bus.fill_busy, bus.consume_busy}), 64'd0);
      chk("flush_done", 64'({bus.fill_done, bus.consume_done}), 64'd0);
      chk("flush_ready", 64'({bus.fill_ready, bus.consume_ready}), 64'b10);
      bus.fill_we = 1'b1;
      tick();
      bus.fill_we = 1'b0;
      chk("idle_fill_we_err", 64'(bus.err), 64'b01);
      chk("idle_fill_we_no_done", 64'(bus.fill_done), 64'd0);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("idle_rd_en_err", 64'(bus.err), 64'b11);
      chk("idle_rd_valid", 64'(bus.rd_valid), 64'd0);

      // Three full rounds; bank order checked inside the tasks.
      for (int r = 1; r <= 3; r++) begin
         for (int b = 0; b < 4; b++) begin
            do_fill(b, 4, 4, r, 1'b0);
            do_consume(b, 4, 4, 1'b0, r);
         end
      end
      chk("wrap_full_count", 64'(bus.full_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
